// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and the
// bit-period derivation used by both directions of the link.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Clock cycles per serial bit, truncated (138 at 16 MHz / 115200).
    function automatic int unsigned clks_per_bit(
        input int unsigned clk_freq,
        input int unsigned bit_rate
    );
        return clk_freq / bit_rate;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Terminal-count bit-period tick generator with synchronous restart.
// Ports: clock, reset (async, active-low), i_restart, o_tick.
module uart_baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 138
) (
    input  logic clock,
    input  logic reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int unsigned CW =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_restart || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_tick = (r_count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, PAYLOAD_BITS data LSB first, one stop bit,
// with a one-word holding register for gap-free back-to-back frames.
// Ports: clock, reset (async, active-low), io_i_data/io_i_valid/io_o_ready
// input handshake, io_o_serial_data line, io_o_tx_done pulse, io_o_busy.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BIT_RATE     = 115200,
    parameter int unsigned CLK_FREQ     = 16_000_000,
    parameter int unsigned PAYLOAD_BITS = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] io_i_data,
    input  logic                    io_i_valid,
    output logic                    io_o_ready,
    output logic                    io_o_serial_data,
    output logic                    io_o_tx_done,
    output logic                    io_o_busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BIT_RATE);
    localparam int unsigned BW =
        (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);

    uart_state_e             r_state;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic [BW-1:0]           r_bit;
    logic [PAYLOAD_BITS-1:0] r_hold_data;
    logic                    r_hold_valid;
    logic                    r_serial;
    logic                    r_done;

    logic                    w_tick_raw;
    logic                    w_tick;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_stop_end;
    logic [PAYLOAD_BITS-1:0] w_shift_next;

    // Counter is held at zero while idle so every frame starts phase-aligned.
    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock    (clock),
        .reset    (reset),
        .i_restart(w_load || (r_state == ST_IDLE)),
        .o_tick   (w_tick_raw)
    );

    assign w_tick       = w_tick_raw && (r_state != ST_IDLE);
    assign w_accept     = io_i_valid && !r_hold_valid;
    assign w_stop_end   = (r_state == ST_STOP) && w_tick;
    // Loading straight out of STOP is what removes the idle gap.
    assign w_load       = r_hold_valid && ((r_state == ST_IDLE) || w_stop_end);
    assign w_shift_next = r_shift >> 1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_accept) begin
            r_hold_data  <= io_i_data;
            r_hold_valid <= 1'b1;
        end else if (w_load) begin
            r_hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bit    <= '0;
            r_serial <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_stop_end;
            if (w_load) begin
                r_state  <= ST_START;
                r_shift  <= r_hold_data;
                r_bit    <= '0;
                r_serial <= 1'b0;
            end else if (w_tick) begin
                unique case (r_state)
                    ST_START: begin
                        r_state  <= ST_DATA;
                        r_bit    <= '0;
                        r_serial <= r_shift[0];
                    end
                    ST_DATA: begin
                        if (r_bit == LAST_BIT) begin
                            r_state  <= ST_STOP;
                            r_serial <= 1'b1;
                        end else begin
                            r_shift  <= w_shift_next;
                            r_bit    <= r_bit + BW'(1);
                            r_serial <= w_shift_next[0];
                        end
                    end
                    ST_STOP: begin
                        r_state  <= ST_IDLE;
                        r_serial <= 1'b1;
                    end
                    ST_IDLE: begin
                        r_serial <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign io_o_ready       = !r_hold_valid;
    assign io_o_serial_data = r_serial;
    assign io_o_tx_done     = r_done;
    assign io_o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: line-level frame decoder and
// timing model driven by directed and random stimulus.
module tb_uart_tx;

    localparam int CPB   = 16_000_000 / 115200;
    localparam int PB    = 8;
    localparam int FRAME = (PB + 2) * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PB-1:0] data = '0;
    logic          valid = 1'b0;
    logic          ready;
    logic          ser;
    logic          done;
    logic          busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mon_cnt = -1;
    int glitch = 0;
    int busy_err = 0;

    logic [PB-1:0] exp_q[$];
    int            start_q[$];
    int            done_q[$];
    logic          lvl[0:PB+1];

    uart_tx dut (
        .clock           (clk),
        .reset           (rst_n),
        .io_i_data       (data),
        .io_i_valid      (valid),
        .io_o_ready      (ready),
        .io_o_serial_data(ser),
        .io_o_tx_done    (done),
        .io_o_busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame decoder: slices the line into FRAME/CPB bit windows by arithmetic.
    initial begin : mon
        int slot;
        logic [PB-1:0] w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_cnt = -1;
                continue;
            end
            if (mon_cnt < 0 && ser == 1'b0) begin
                mon_cnt = 0;
                start_q.push_back(cyc);
            end
            if (mon_cnt >= 0) begin
                if (!busy) busy_err++;
                slot = mon_cnt / CPB;
                if (mon_cnt % CPB == 0) lvl[slot] = ser;
                else if (ser !== lvl[slot]) glitch++;
                if (mon_cnt == FRAME - 1) begin
                    for (int i = 0; i < PB; i++) w[i] = lvl[i+1];
                    check("stop_bit", 32'(lvl[PB+1]), 32'd1);
                    if (exp_q.size() == 0)
                        check("unexpected_frame", 32'(w), 32'hFFFF_FFFF);
                    else
                        check("rx_word", 32'(w), 32'(exp_q.pop_front()));
                    mon_cnt = -1;
                end else begin
                    mon_cnt++;
                end
            end else if (busy) begin
                busy_err++;
            end
            if (done) done_q.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PB-1:0] d, input bit churn,
                        output int acc);
        data  = d;
        valid = 1'b1;
        acc   = -1;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (ready) begin
                acc = cyc;
                exp_q.push_back(data);
                break;
            end
            if (churn && (k % 97 == 50)) data = PB'($urandom_range(255));
        end
        if (acc < 0) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        data  = PB'($urandom_range(255));
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (!busy && ready && mon_cnt < 0 && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_idle_timeout"}, 32'(ok), 32'd1);
        tick(4);
        check({tag, "_glitch"}, 32'(glitch), 32'd0);
        check({tag, "_busy_track"}, 32'(busy_err), 32'd0);
        glitch   = 0;
        busy_err = 0;
    endtask

    task automatic clear_obs();
        start_q.delete();
        done_q.delete();
    endtask

    task automatic check_timing(input string tag, input int n);
        check({tag, "_frames"}, 32'(start_q.size()), 32'(n));
        check({tag, "_dones"}, 32'(done_q.size()), 32'(n));
        if (start_q.size() == n && done_q.size() == n)
            for (int i = 0; i < n; i++)
                check({tag, "_done_at"}, 32'(done_q[i] - start_q[i]),
                      32'(FRAME));
    endtask

    initial begin : watchdog
        #2_000_000;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : main
        int acc;
        int acc2;
        int lows;
        int nready;
        int nbusy;
        int ndone;
        bit ok;

        // Reset and long idle
        tick(5);
        @(negedge clk);
        check("rst_line", 32'(ser), 32'd1);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tick(1);
        rst_n = 1'b1;
        lows = 0; nready = 0; nbusy = 0; ndone = 0;
        repeat (2000) begin
            @(negedge clk);
            if (!ser) lows++;
            if (!ready) nready++;
            if (busy) nbusy++;
            if (done) ndone++;
        end
        check("idle_line_low", 32'(lows), 32'd0);
        check("idle_not_ready", 32'(nready), 32'd0);
        check("idle_busy", 32'(nbusy), 32'd0);
        check("idle_done", 32'(ndone), 32'd0);
        tick(1);

        // Single frame 0x16
        clear_obs();
        send(8'h16, 1'b0, acc);
        wait_idle("single");
        check_timing("single", 1);
        if (start_q.size() == 1)
            check("single_latency", 32'(start_q[0] - acc), 32'd2);

        // Back-to-back
        clear_obs();
        send(8'h16, 1'b0, acc);
        check("b2b_ready_drop", 32'(ready), 32'd0);
        send(8'h32, 1'b0, acc2);
        check("b2b_ready_full", 32'(ready), 32'd0);
        send(8'hAF, 1'b0, acc2);
        wait_idle("b2b");
        check_timing("b2b", 3);
        if (start_q.size() == 3) begin
            check("b2b_gap1", 32'(start_q[1] - start_q[0]), 32'(FRAME));
            check("b2b_gap2", 32'(start_q[2] - start_q[1]), 32'(FRAME));
            check("b2b_span", 32'(start_q[2] + FRAME - start_q[0]),
                  32'(3 * FRAME));
        end

        // Backpressure with data changing while blocked
        clear_obs();
        send(8'h3C, 1'b0, acc);
        send(PB'($urandom_range(255)), 1'b0, acc);
        check("bp_ready_low", 32'(ready), 32'd0);
        send(PB'($urandom_range(255)), 1'b1, acc);
        wait_idle("bp");
        check_timing("bp", 3);

        // Reset during data bit 3
        clear_obs();
        send(8'hA5, 1'b0, acc);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (mon_cnt >= 4 * CPB + 40) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_reach_bit3", 32'(ok), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_line", 32'(ser), 32'd1);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_ready", 32'(ready), 32'd1);
        check("mid_done", 32'(done), 32'd0);
        exp_q.delete();
        tick(3);
        rst_n = 1'b1;
        tick(2);
        clear_obs();
        glitch   = 0;
        busy_err = 0;
        send(8'h55, 1'b0, acc);
        wait_idle("post_rst");
        check_timing("post_rst", 1);
        if (start_q.size() == 1)
            check("post_rst_latency", 32'(start_q[0] - acc), 32'd2);

        // Random words, random gaps, occasional churn
        clear_obs();
        for (int i = 0; i < 6; i++) begin
            send(PB'($urandom_range(255)), 1'($urandom_range(1)), acc);
            tick($urandom_range(300));
        end
        wait_idle("rand");
        check_timing("rand", 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
